// File: rtl/ble_rx_crc_seq_ctrl.sv
// Sequences the RX payload CRC-16 checker for one packet. It clears and seeds the checker,
// feeds it the payload bits, collects the received CRC field and reports a pass/fail verdict.
module ble_rx_crc_seq_ctrl #(
  parameter int LEN_W = 10,
  parameter int CRC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] payload_len,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             crc_clear_out,
  output logic             crc_valid_out,
  output logic             crc_data_out,
  input  logic [CRC_W-1:0] crc_reg_in,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [7:0]       err_cnt
);

  localparam int CNT_W = LEN_W + 3;

  typedef enum logic [2:0] {IDLE, CLEAR, PAYLOAD, CRC_RX, COMPARE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   bit_target_reg, bit_target_next;
  logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [CRC_W-1:0]   rx_crc_reg, rx_crc_next;
  logic               crc_ok_reg, crc_ok_next;
  logic [7:0]         err_cnt_reg, err_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_target_reg <= '0;
      bit_cnt_reg    <= '0;
      rx_crc_reg     <= '0;
      crc_ok_reg     <= 1'b0;
      err_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      bit_target_reg <= bit_target_next;
      bit_cnt_reg    <= bit_cnt_next;
      rx_crc_reg     <= rx_crc_next;
      crc_ok_reg     <= crc_ok_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_target_next = bit_target_reg;
    bit_cnt_next    = bit_cnt_reg;
    rx_crc_next     = rx_crc_reg;
    crc_ok_next     = crc_ok_reg;
    err_cnt_next    = err_cnt_reg;

    // The checker sees payload bits with zero latency so it stays in lockstep with the deframer.
    bit_ready     = (state_reg == PAYLOAD) || (state_reg == CRC_RX);
    crc_clear_out = (state_reg == CLEAR);
    crc_valid_out = (state_reg == PAYLOAD) && bit_valid;
    crc_data_out  = (state_reg == PAYLOAD) && bit_in;
    busy          = (state_reg != IDLE);
    done          = (state_reg == DONE);

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          bit_target_next = {payload_len, 3'b000};
          bit_cnt_next    = '0;
          crc_ok_next     = 1'b0;
          state_next      = CLEAR;
        end
      end
      CLEAR: begin
        state_next = (bit_target_reg != '0) ? PAYLOAD : CRC_RX;
      end
      PAYLOAD: begin
        if (bit_valid) begin
          if (bit_cnt_reg == bit_target_reg - CNT_W'(1)) begin
            bit_cnt_next = '0;
            state_next   = CRC_RX;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      CRC_RX: begin
        // bit_cnt is reused to count the received CRC bits.
        if (bit_valid) begin
          rx_crc_next = {rx_crc_reg[CRC_W-2:0], bit_in};
          if (bit_cnt_reg == CNT_W'(CRC_W - 1)) begin
            bit_cnt_next = '0;
            state_next   = COMPARE;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      COMPARE: begin
        crc_ok_next = (rx_crc_reg == crc_reg_in);
        if ((rx_crc_reg != crc_reg_in) && (err_cnt_reg != 8'hFF))
          err_cnt_next = err_cnt_reg + 8'd1;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort discards the packet without touching the verdict or the error count.
    if (abort && (state_reg != IDLE)) begin
      state_next   = IDLE;
      crc_ok_next  = crc_ok_reg;
      err_cnt_next = err_cnt_reg;
    end
  end

  assign crc_ok  = crc_ok_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_ble_rx_crc_seq_ctrl.sv
// Bench for ble_rx_crc_seq_ctrl: a behavioural CRC-16 checker stands in for decrc16, and a
// vector table plus directed sequences exercise length, gaps, errors, abort and reset.
module tb_ble_rx_crc_seq_ctrl;

  localparam logic [15:0] SEED = 16'h00E2;  // remainder after clear with uap seed 0x47

  logic        clk = 1'b0;
  logic        reset, start, abort, bit_in, bit_valid;
  logic [9:0]  payload_len;
  logic        bit_ready, crc_clear_out, crc_valid_out, crc_data_out;
  logic [15:0] crc_reg_in;
  logic        busy, done, crc_ok;
  logic [7:0]  err_cnt;

  ble_rx_crc_seq_ctrl #(.LEN_W(10), .CRC_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .payload_len(payload_len), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .crc_clear_out(crc_clear_out),
    .crc_valid_out(crc_valid_out), .crc_data_out(crc_data_out),
    .crc_reg_in(crc_reg_in), .busy(busy), .done(done),
    .crc_ok(crc_ok), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [7:0]  b0, b1, b2;
    logic [15:0] flip;
    bit          gaps;
    bit          exp_ok;
    int          exp_v;
  } vec_t;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int vcnt = 0;
  int done_cnt = 0;
  int exp_err = 0;
  logic [15:0] chk_crc = 16'h0;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] crc_of(input vec_t v);
    logic [15:0] c;
    logic [7:0]  byt [3];
    byt[0] = v.b0; byt[1] = v.b1; byt[2] = v.b2;
    c = SEED;
    for (int i = 0; i < v.len; i++)
      for (int j = 7; j >= 0; j--)
        c = crc_step(c, byt[i][j]);
    return c;
  endfunction

  // Behavioural stand-in for the decrc16 checker, driven only by the DUT outputs.
  always @(posedge clk) begin
    if (crc_clear_out)      chk_crc <= SEED;
    else if (crc_valid_out) chk_crc <= crc_step(chk_crc, crc_data_out);
    if (crc_valid_out) vcnt <= vcnt + 1;
    if (done)          done_cnt <= done_cnt + 1;
  end
  assign crc_reg_in = chk_crc;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_packet(input vec_t v, input int mid_start);
    logic [15:0] exp_crc;
    logic        q[$];
    logic [7:0]  byt [3];
    int          vc0, c0, it;
    logic        acc;
    byt[0] = v.b0; byt[1] = v.b1; byt[2] = v.b2;
    exp_crc = crc_of(v);
    for (int i = 0; i < v.len; i++)
      for (int j = 7; j >= 0; j--)
        q.push_back(byt[i][j]);
    for (int j = 15; j >= 0; j--)
      q.push_back(exp_crc[j] ^ v.flip[j]);

    vc0 = vcnt;
    payload_len = 10'(v.len);
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
    chk("clear_pulse", 32'(crc_clear_out), 32'd1);
    chk("ready_in_clear", 32'(bit_ready), 32'd0);
    chk("ok_cleared_on_start", 32'(crc_ok), 32'd0);

    it = 0;
    while (q.size() > 0 && it < 4000) begin
      bit_in    = q[0];
      bit_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (it == mid_start) begin
        start = 1'b1;
        payload_len = 10'd3;
      end
      acc = bit_valid && bit_ready;
      tick();
      start = 1'b0;
      payload_len = 10'(v.len);
      if (acc) void'(q.pop_front());
      it++;
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    chk("bits_consumed", 32'(q.size()), 32'd0);
    chk("ready_in_compare", 32'(bit_ready), 32'd0);
    chk("done_before_compare", 32'(done), 32'd0);
    for (int k = 0; k < 4 && !done; k++) tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_in_done", 32'(bit_ready), 32'd0);
    if (!v.gaps) chk("latency", 32'(cyc - c0), 32'(18 + 8 * v.len));
    if (!v.exp_ok && exp_err < 255) exp_err++;
    chk("crc_ok", 32'(crc_ok), 32'(v.exp_ok));
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
    chk("valid_pulses", 32'(vcnt - vc0), 32'(v.exp_v));
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("ok_held", 32'(crc_ok), 32'(v.exp_ok));
    $display("pkt len=%0d gaps=%0b flip=%04h crc_ok=%0b err_cnt=%0d", v.len, v.gaps, v.flip,
             crc_ok, err_cnt);
  endtask

  vec_t tbl [6];
  vec_t bad;
  vec_t good1;
  int   dc0;

  initial begin
    tbl[0] = '{len: 0, b0: 8'h00, b1: 8'h00, b2: 8'h00, flip: 16'h0000, gaps: 0, exp_ok: 1, exp_v: 0};
    tbl[1] = '{len: 1, b0: 8'hA5, b1: 8'h00, b2: 8'h00, flip: 16'h0000, gaps: 0, exp_ok: 1, exp_v: 8};
    tbl[2] = '{len: 1, b0: 8'hA5, b1: 8'h00, b2: 8'h00, flip: 16'h0001, gaps: 0, exp_ok: 0, exp_v: 8};
    tbl[3] = '{len: 3, b0: 8'h3C, b1: 8'h5A, b2: 8'h96, flip: 16'h0000, gaps: 1, exp_ok: 1, exp_v: 24};
    tbl[4] = '{len: 2, b0: 8'hFF, b1: 8'h00, b2: 8'h00, flip: 16'h8000, gaps: 0, exp_ok: 0, exp_v: 16};
    tbl[5] = '{len: 3, b0: 8'h01, b1: 8'h80, b2: 8'h7E, flip: 16'h0100, gaps: 1, exp_ok: 0, exp_v: 24};
    good1 = tbl[1];
    bad   = tbl[2];

    reset = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b1; bit_valid = 1'b1;
    payload_len = 10'd0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_crc_ok", 32'(crc_ok), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_bit_ready", 32'(bit_ready), 32'd0);
    chk("rst_clear", 32'(crc_clear_out), 32'd0);
    chk("rst_valid", 32'(crc_valid_out), 32'd0);
    reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_packet(tbl[i], -1);

    // Abort after five payload bits: no verdict, then a clean packet must still verify.
    dc0 = done_cnt;
    payload_len = 10'd2; start = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_crc_ok", 32'(crc_ok), 32'd0);
    chk("abort_err_cnt", 32'(err_cnt), 32'(exp_err));
    tick(); tick(); tick();
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    run_packet(good1, -1);

    // Abort beats a simultaneous start in IDLE.
    abort = 1'b1; start = 1'b1; payload_len = 10'd1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_idle", 32'(busy), 32'd0);
    chk("abort_start_noclear", 32'(crc_clear_out), 32'd0);

    // A start during PAYLOAD must not retarget the length.
    run_packet(good1, 4);

    for (int r = 0; r < 300; r++) run_packet(bad, -1);
    chk("err_saturated", 32'(err_cnt), 32'd255);

    // Reset during CRC_RX.
    payload_len = 10'd1; start = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; bit_valid = 1'b0;
    exp_err = 0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_crc_ok", 32'(crc_ok), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick();
    run_packet(tbl[4], -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
